// File: rtl/bsg_axil_mcl_pkg.sv
// bsg_axil_mcl_pkg: MCL packet layout shared by both ends of the AXI-Lite MCL link
// Request pkt (LSB first): wdata[31:0], addr[63:32], wstrb[67:64], is_write[68].
// Response pkt (LSB first): rdata[31:0], resp[33:32], is_write[34]; wider fifo bits are zero.
package bsg_axil_mcl_pkg;
  localparam int mcl_min_width_lp = 69;
  localparam logic [1:0] axil_resp_okay = 2'b00;
  localparam logic [1:0] axil_resp_slverr = 2'b10;
  typedef struct packed {
    logic        is_write;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mcl_req_s;
  typedef struct packed {
    logic        is_write;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } mcl_rsp_s;
  typedef enum logic [2:0] {s_idle, s_wr, s_bwait, s_rd, s_rwait, s_rsp} state_e;
  function automatic mcl_rsp_s mk_rsp(input logic is_write, input logic [1:0] resp, input logic [31:0] rdata);
    return '{is_write: is_write, resp: resp, rdata: rdata};
  endfunction
endpackage

// File: rtl/m_axil_mcl_adapter.sv
// m_axil_mcl_adapter: pops MCL request packets, runs one AXI-Lite transaction each, pushes responses
// Ports: clk_i, reset_i (async, active-high); mcl_v_i/mcl_data_i/mcl_yumi_o request side;
//   mcl_v_o/mcl_data_o/mcl_ready_i response side; m_axil_mcl_{aw,w,b,ar,r}* AXI-Lite master.
module m_axil_mcl_adapter
  import bsg_axil_mcl_pkg::*;
#(
  parameter int fifo_width_p = 128,
  parameter bit write_rsp_p  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    mcl_v_i,
  input  logic [fifo_width_p-1:0] mcl_data_i,
  output logic                    mcl_yumi_o,
  output logic                    mcl_v_o,
  output logic [fifo_width_p-1:0] mcl_data_o,
  input  logic                    mcl_ready_i,
  output logic [31:0]             m_axil_mcl_awaddr,
  output logic                    m_axil_mcl_awvalid,
  input  logic                    m_axil_mcl_awready,
  output logic [31:0]             m_axil_mcl_wdata,
  output logic [3:0]              m_axil_mcl_wstrb,
  output logic                    m_axil_mcl_wvalid,
  input  logic                    m_axil_mcl_wready,
  input  logic [1:0]              m_axil_mcl_bresp,
  input  logic                    m_axil_mcl_bvalid,
  output logic                    m_axil_mcl_bready,
  output logic [31:0]             m_axil_mcl_araddr,
  output logic                    m_axil_mcl_arvalid,
  input  logic                    m_axil_mcl_arready,
  input  logic [31:0]             m_axil_mcl_rdata,
  input  logic [1:0]              m_axil_mcl_rresp,
  input  logic                    m_axil_mcl_rvalid,
  output logic                    m_axil_mcl_rready
);
  if (fifo_width_p < mcl_min_width_lp) begin : g_width_chk
    $error("fifo_width_p must be at least %0d", mcl_min_width_lp);
  end
  if (fifo_width_p > mcl_min_width_lp) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^mcl_data_i[fifo_width_p-1:mcl_min_width_lp];
  end
  state_e      state;
  mcl_req_s    req_n;
  logic [31:0] addr_r;
  logic        aw_done, w_done;
  assign req_n = mcl_data_i[mcl_min_width_lp-1:0];
  assign mcl_yumi_o = (state == s_idle) & mcl_v_i;
  assign m_axil_mcl_awaddr = addr_r;
  assign m_axil_mcl_araddr = addr_r;
  // A channel's valid dropping is its "sent" flag; done also covers the handshake happening now.
  assign aw_done = ~m_axil_mcl_awvalid | m_axil_mcl_awready;
  assign w_done  = ~m_axil_mcl_wvalid | m_axil_mcl_wready;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state              <= s_idle;
      addr_r             <= '0;
      m_axil_mcl_wdata   <= '0;
      m_axil_mcl_wstrb   <= '0;
      m_axil_mcl_awvalid <= 1'b0;
      m_axil_mcl_wvalid  <= 1'b0;
      m_axil_mcl_bready  <= 1'b0;
      m_axil_mcl_arvalid <= 1'b0;
      m_axil_mcl_rready  <= 1'b0;
      mcl_v_o            <= 1'b0;
      mcl_data_o         <= '0;
    end else
      case (state)
        s_idle: if (mcl_v_i) begin
          addr_r           <= req_n.addr;
          m_axil_mcl_wdata <= req_n.wdata;
          m_axil_mcl_wstrb <= req_n.wstrb;
          // Misaligned addresses never reach the bus; they are answered locally with SLVERR.
          if (req_n.addr[1:0] != 2'b00) begin
            state      <= s_rsp;
            mcl_v_o    <= 1'b1;
            mcl_data_o <= fifo_width_p'(mk_rsp(req_n.is_write, axil_resp_slverr, 32'h0));
          end else if (req_n.is_write) begin
            state              <= s_wr;
            m_axil_mcl_awvalid <= 1'b1;
            m_axil_mcl_wvalid  <= 1'b1;
          end else begin
            state              <= s_rd;
            m_axil_mcl_arvalid <= 1'b1;
          end
        end
        s_wr: begin
          if (m_axil_mcl_awready) m_axil_mcl_awvalid <= 1'b0;
          if (m_axil_mcl_wready) m_axil_mcl_wvalid <= 1'b0;
          if (aw_done & w_done) begin
            state             <= s_bwait;
            m_axil_mcl_bready <= 1'b1;
          end
        end
        s_bwait: if (m_axil_mcl_bvalid) begin
          m_axil_mcl_bready <= 1'b0;
          state             <= write_rsp_p ? s_rsp : s_idle;
          mcl_v_o           <= write_rsp_p;
          mcl_data_o        <= fifo_width_p'(mk_rsp(1'b1, m_axil_mcl_bresp, 32'h0));
        end
        s_rd: if (m_axil_mcl_arready) begin
          m_axil_mcl_arvalid <= 1'b0;
          m_axil_mcl_rready  <= 1'b1;
          state              <= s_rwait;
        end
        s_rwait: if (m_axil_mcl_rvalid) begin
          m_axil_mcl_rready <= 1'b0;
          mcl_v_o           <= 1'b1;
          mcl_data_o        <= fifo_width_p'(mk_rsp(1'b0, m_axil_mcl_rresp, m_axil_mcl_rdata));
          state             <= s_rsp;
        end
        s_rsp: if (mcl_ready_i) begin
          mcl_v_o <= 1'b0;
          state   <= s_idle;
        end
        default: state <= s_idle;
      endcase
endmodule

// File: tb/tb_m_axil_mcl_adapter.sv
// tb_m_axil_mcl_adapter: scoreboard bench for the AXI-Lite MCL master adapter (write_rsp_p 1 and 0)
module tb_m_axil_mcl_adapter;
  import bsg_axil_mcl_pkg::*;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic v_i, yumi, v_o, ready_i;
  logic [W-1:0] data_i, data_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic v0, yumi0, v_o0, ready0;
  logic [W-1:0] data0, data_o0;
  logic [31:0] awaddr0, wdata0, araddr0, rdata0;
  logic [3:0] wstrb0;
  logic awvalid0, awready0, wvalid0, wready0, bvalid0, bready0, arvalid0, arready0, rvalid0, rready0;
  logic [1:0] bresp0, rresp0;

  m_axil_mcl_adapter #(.fifo_width_p(W), .write_rsp_p(1'b1)) u_dut (
    .clk_i(clk), .reset_i(rst), .mcl_v_i(v_i), .mcl_data_i(data_i), .mcl_yumi_o(yumi),
    .mcl_v_o(v_o), .mcl_data_o(data_o), .mcl_ready_i(ready_i),
    .m_axil_mcl_awaddr(awaddr), .m_axil_mcl_awvalid(awvalid), .m_axil_mcl_awready(awready),
    .m_axil_mcl_wdata(wdata), .m_axil_mcl_wstrb(wstrb), .m_axil_mcl_wvalid(wvalid), .m_axil_mcl_wready(wready),
    .m_axil_mcl_bresp(bresp), .m_axil_mcl_bvalid(bvalid), .m_axil_mcl_bready(bready),
    .m_axil_mcl_araddr(araddr), .m_axil_mcl_arvalid(arvalid), .m_axil_mcl_arready(arready),
    .m_axil_mcl_rdata(rdata), .m_axil_mcl_rresp(rresp), .m_axil_mcl_rvalid(rvalid), .m_axil_mcl_rready(rready));

  m_axil_mcl_adapter #(.fifo_width_p(W), .write_rsp_p(1'b0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .mcl_v_i(v0), .mcl_data_i(data0), .mcl_yumi_o(yumi0),
    .mcl_v_o(v_o0), .mcl_data_o(data_o0), .mcl_ready_i(ready0),
    .m_axil_mcl_awaddr(awaddr0), .m_axil_mcl_awvalid(awvalid0), .m_axil_mcl_awready(awready0),
    .m_axil_mcl_wdata(wdata0), .m_axil_mcl_wstrb(wstrb0), .m_axil_mcl_wvalid(wvalid0), .m_axil_mcl_wready(wready0),
    .m_axil_mcl_bresp(bresp0), .m_axil_mcl_bvalid(bvalid0), .m_axil_mcl_bready(bready0),
    .m_axil_mcl_araddr(araddr0), .m_axil_mcl_arvalid(arvalid0), .m_axil_mcl_arready(arready0),
    .m_axil_mcl_rdata(rdata0), .m_axil_mcl_rresp(rresp0), .m_axil_mcl_rvalid(rvalid0), .m_axil_mcl_rready(rready0));

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [68:0] mk_req(input logic wr, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    return {wr, s, a, d};
  endfunction

  // slave model for u_dut: configurable AW/W ready delays, B/R answered one cycle after handshakes
  int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0, b_count = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0, b_hold = 0;
  logic [1:0] b_cfg = 2'b00, r_cfg = 2'b00;
  logic [31:0] rd_cfg = 32'h0, got_awaddr = 32'h0, got_wdata = 32'h0, got_araddr = 32'h0;
  logic [3:0] got_wstrb = 4'h0;
  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (b_fire) begin bvalid = 0; b_fire = 0; end
        if (r_fire) begin rvalid = 0; r_fire = 0; end
        if (aw_got && w_got && !b_hold) begin bvalid = 1; bresp = b_cfg; aw_got = 0; w_got = 0; end
        if (ar_got) begin rvalid = 1; rdata = rd_cfg; rresp = r_cfg; ar_got = 0; end
        awready = awvalid && aw_cnt >= aw_dly;
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        wready = wvalid && w_cnt >= w_dly;
        w_cnt = wvalid ? w_cnt + 1 : 0;
        arready = arvalid;
        if (awvalid && awready) begin aw_got = 1; got_awaddr = awaddr; end
        if (wvalid && wready) begin w_got = 1; got_wdata = wdata; got_wstrb = wstrb; end
        if (arvalid && arready) begin ar_got = 1; got_araddr = araddr; end
        if (bvalid && bready) begin b_fire = 1; b_count++; end
        if (rvalid && rready) r_fire = 1;
      end
    end
  end

  // slave model and counters for u_dut0 (always ready)
  int b0_count = 0, rsp0_count = 0, yumi0_count = 0, axi_v_cnt0 = 0;
  bit aw0_got = 0, w0_got = 0, b0_fire = 0;
  logic [W-1:0] rsp0_last = '0;
  initial begin
    awready0 = 1; wready0 = 1; arready0 = 1; rvalid0 = 0; rdata0 = 0; rresp0 = 0; bvalid0 = 0; bresp0 = 0;
    forever begin
      @(negedge clk);
      if (b0_fire) begin bvalid0 = 0; b0_fire = 0; end
      if (aw0_got && w0_got) begin bvalid0 = 1; aw0_got = 0; w0_got = 0; end
      if (awvalid0) aw0_got = 1;
      if (wvalid0) w0_got = 1;
      if (bvalid0 && bready0) begin b0_fire = 1; b0_count++; end
      axi_v_cnt0 += int'(awvalid0 | wvalid0 | arvalid0);
      yumi0_count += int'(yumi0);
      if (v_o0 && ready0) begin rsp0_count++; rsp0_last = data_o0; end
    end
  end

  // scoreboard monitor for u_dut responses
  logic [W-1:0] exp_q[$];
  int axi_v_cnt = 0;
  initial forever begin
    @(negedge clk);
    axi_v_cnt += int'(awvalid | wvalid | arvalid);
    if (v_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h with no response outstanding", data_o);
      end else check("rsp_pkt", data_o, exp_q.pop_front());
    end
  end

  task automatic send1(input logic [68:0] pkt, input bit hold);
    v_i = 1;
    data_i = W'(pkt);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (yumi) break;
      if (n == 100) begin fail_to("yumi"); break; end
    end
    @(posedge clk); #1;
    if (!hold) v_i = 0;
  endtask

  task automatic send0(input logic [68:0] pkt, input bit hold);
    v0 = 1;
    data0 = W'(pkt);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (yumi0) break;
      if (n == 100) begin fail_to("yumi0"); break; end
    end
    @(posedge clk); #1;
    if (!hold) v0 = 0;
  endtask

  task automatic drain();
    for (int n = 0; exp_q.size() != 0; n++) begin
      if (n == 200) begin fail_to("drain"); break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc, vc;
    rst = 1; v_i = 0; data_i = '0; ready_i = 1; v0 = 0; data0 = '0; ready0 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, v_o}, 6'b0);
    check("rst_regs", {awaddr, wdata, wstrb, araddr}, '0);
    check("rst_data", data_o, '0);
    rst = 0;
    @(posedge clk); #1;
    // 1: zero-wait read, latency c1/c2/c3
    rd_cfg = 32'hDEADBEEF; r_cfg = axil_resp_okay;
    exp_q.push_back(W'(35'h0_DEAD_BEEF));
    send1(mk_req(1'b0, 4'h0, 32'h0000_0104, 32'h0), 1'b0);
    check("rd_c1", {arvalid, rready, v_o}, 3'b100);
    @(posedge clk); #1;
    check("rd_c2", {arvalid, rready, v_o}, 3'b010);
    @(posedge clk); #1;
    check("rd_c3", {arvalid, rready, v_o}, 3'b001);
    drain();
    check("rd_araddr", got_araddr, 32'h0000_0104);
    // 2: AW accepted 3 cycles before W
    aw_dly = 0; w_dly = 3; b_cfg = 2'b00; bc = b_count;
    exp_q.push_back(W'(35'h4_0000_0000));
    send1(mk_req(1'b1, 4'b0011, 32'h10, 32'h12345678), 1'b0);
    check("wr_c1_aw_w", {awvalid, wvalid}, 2'b11);
    @(posedge clk); #1;
    check("wr_c2_w_only", {awvalid, wvalid}, 2'b01);
    drain();
    check("wr_b_count", b_count - bc, 1);
    check("wr_awaddr", got_awaddr, 32'h10);
    check("wr_wdata", got_wdata, 32'h12345678);
    check("wr_wstrb", got_wstrb, 4'b0011);
    // zero-wait write with a non-standard bresp passed through
    w_dly = 0; b_cfg = 2'b11;
    exp_q.push_back(W'(35'h7_0000_0000));
    send1(mk_req(1'b1, 4'hF, 32'h20, 32'hA5A5_5A5A), 1'b0);
    check("wr0_c1", {awvalid, wvalid, bready}, 3'b110);
    @(posedge clk); #1;
    check("wr0_c2", {awvalid, wvalid, bready}, 3'b001);
    @(posedge clk); #1;
    check("wr0_c3", v_o, 1'b1);
    drain();
    // 3: misaligned read and write answered with SLVERR, no bus traffic
    vc = axi_v_cnt;
    exp_q.push_back(W'(35'h2_0000_0000));
    send1(mk_req(1'b0, 4'h0, 32'h0000_0102, 32'h0), 1'b0);
    exp_q.push_back(W'(35'h6_0000_0000));
    send1(mk_req(1'b1, 4'hF, 32'h0000_0103, 32'h55), 1'b0);
    drain();
    check("unal_no_axi", axi_v_cnt - vc, 0);
    send0(mk_req(1'b1, 4'hF, 32'h0000_0102, 32'h1), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("unal0_rsp_count", rsp0_count, 1);
    check("unal0_rsp", rsp0_last, W'(35'h6_0000_0000));
    check("unal0_no_axi", axi_v_cnt0, 0);
    // 4: write_rsp_p=0, eight back-to-back writes
    for (int i = 0; i < 8; i++) send0(mk_req(1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'(i)), i != 7);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_b_count", b0_count, 8);
    check("b2b_no_rsp", rsp0_count, 1);
    check("b2b_yumi", yumi0_count, 9);
    // 5: response backpressure with a new request waiting
    ready_i = 0; rd_cfg = 32'hCAFEF00D; r_cfg = 2'b01;
    exp_q.push_back(W'(35'h1_CAFE_F00D));
    send1(mk_req(1'b0, 4'h0, 32'h200, 32'h0), 1'b0);
    exp_q.push_back(W'(35'h1_CAFE_F00D));
    v_i = 1;
    data_i = W'(mk_req(1'b0, 4'h0, 32'h300, 32'h0));
    for (int n = 0; !v_o; n++) begin
      if (n == 50) begin fail_to("bp_v_o"); break; end
      @(negedge clk);
    end
    repeat (10) begin
      @(negedge clk);
      check("bp_v_yumi", {v_o, yumi}, 2'b10);
      check("bp_data", data_o, W'(35'h1_CAFE_F00D));
    end
    @(posedge clk); #1;
    ready_i = 1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (yumi) break;
      if (n == 50) begin fail_to("bp_yumi"); break; end
    end
    @(posedge clk); #1;
    v_i = 0;
    drain();
    check("bp_araddr", got_araddr, 32'h300);
    // 6: reset while waiting for B, then a normal read
    b_hold = 1;
    send1(mk_req(1'b1, 4'hF, 32'h40, 32'h77), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("bwait_bready", bready, 1'b1);
    rst = 1;
    #1;
    check("rst_async_valids", {awvalid, wvalid, bready, arvalid, rready, v_o}, 6'b0);
    @(posedge clk); #1;
    rst = 0; b_hold = 0;
    rd_cfg = 32'h0BAD_F00D; r_cfg = 2'b00;
    exp_q.push_back(W'(35'h0_0BAD_F00D));
    send1(mk_req(1'b0, 4'h0, 32'h44, 32'h0), 1'b0);
    drain();
    check("post_rst_araddr", got_araddr, 32'h44);
    repeat (3) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
